// File: rtl/alu_nzcv_pipe.sv
// -----------------------------------------------------------------------------
// alu_nzcv_pipe
//
// Registered NZCV ALU. It sits between operand fetch and writeback. It accepts
// one operation per cycle over a valid/ready handshake and presents the result
// one cycle later. It also holds an architectural NZCV flags register, which
// later conditional instructions read.
//
// Opcodes (i_alu_ctrl):
//   000 ADD   a + b
//   001 SUB   a - b            (a + ~b + 1)
//   010 AND   a & b
//   011 ORR   a | b
//   100 ADC   a + b + C
//   101 SBC   a - b - !C       (a + ~b + C)
//   110 EOR   a ^ b
//   111 MOV   b
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream operation valid
//   o_ready      operation can be accepted this cycle (~o_valid | i_ready)
//   i_a, i_b     operands, N bits
//   i_alu_ctrl   opcode, see table above
//   i_set_flags  1: load the flags register with this operation's flags
//   o_valid      o_result holds a completed operation
//   i_ready      downstream takes o_result
//   o_result     registered result, N bits
//   o_nzcv       flags register {N, Z, C, V}
// -----------------------------------------------------------------------------
module alu_nzcv_pipe #(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_alu_ctrl,
    input  logic         i_set_flags,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_nzcv
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;
    localparam logic [2:0] OP_SBC = 3'b101;
    localparam logic [2:0] OP_EOR = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    // Overflow means both addends have the same sign and the sum has the
    // other sign. b_eff is the operand after the optional inversion for
    // subtraction, so this one rule serves all four arithmetic opcodes.
    function automatic logic [3:0] arith_flags(
        input logic [N-1:0] a,
        input logic [N-1:0] b_eff,
        input logic [N-1:0] res,
        input logic         cout
    );
        logic n_f;
        logic z_f;
        logic v_f;
        n_f = res[N-1];
        z_f = (res == '0);
        v_f = (a[N-1] == b_eff[N-1]) && (res[N-1] != a[N-1]);
        return {n_f, z_f, cout, v_f};
    endfunction

    // Logical ops and MOV clear C and V.
    function automatic logic [3:0] logic_flags(input logic [N-1:0] res);
        return {res[N-1], (res == '0), 1'b0, 1'b0};
    endfunction

    // -------------------------------------------------------------------------
    // Control and registered state
    // -------------------------------------------------------------------------
    logic         vld_p1;
    logic [N-1:0] result_p1;
    logic [3:0]   flags_p1;
    logic         accept_p0;

    assign o_ready   = ~vld_p1 | i_ready;
    assign accept_p0 = i_valid & o_ready;

    // -------------------------------------------------------------------------
    // Stage p0: operand conditioning and compute
    // -------------------------------------------------------------------------
    logic         is_arith_p0;
    logic         is_sub_p0;
    logic         cin_p0;
    logic [N-1:0] b_eff_p0;
    logic [N:0]   sum_p0;
    logic [N-1:0] logic_res_p0;
    logic [N-1:0] res_p0;
    logic [3:0]   flags_p0;

    // Arithmetic opcodes all have ctrl[1]=0. Subtraction has ctrl[0]=1 within
    // that group. ADD/SUB take their carry-in from ctrl[0] (0 for ADD, 1 for
    // SUB). ADC/SBC take the carry-in from the flags register as it currently
    // stands. A flag-setting op accepted on the previous edge has already
    // written that register, so the C it produced is visible here.
    assign is_arith_p0 = ~i_alu_ctrl[1];
    assign is_sub_p0   = is_arith_p0 & i_alu_ctrl[0];
    assign cin_p0      = i_alu_ctrl[2] ? flags_p1[1] : i_alu_ctrl[0];
    assign b_eff_p0    = is_sub_p0 ? ~i_b : i_b;

    // Computed at N+1 bits so that the top bit is the carry-out.
    assign sum_p0 = {1'b0, i_a} + {1'b0, b_eff_p0} + {{N{1'b0}}, cin_p0};

    always_comb begin
        logic_res_p0 = '0;
        case (i_alu_ctrl)
            OP_AND:  logic_res_p0 = i_a & i_b;
            OP_ORR:  logic_res_p0 = i_a | i_b;
            OP_EOR:  logic_res_p0 = i_a ^ i_b;
            OP_MOV:  logic_res_p0 = i_b;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: logic_res_p0 = '0;
            default: logic_res_p0 = '0;
        endcase
    end

    always_comb begin
        res_p0   = '0;
        flags_p0 = '0;
        if (is_arith_p0) begin
            res_p0   = sum_p0[N-1:0];
            flags_p0 = arith_flags(i_a, b_eff_p0, sum_p0[N-1:0], sum_p0[N]);
        end else begin
            res_p0   = logic_res_p0;
            flags_p0 = logic_flags(logic_res_p0);
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: output register and architectural flags
    // -------------------------------------------------------------------------
    // Reset takes priority over an accept in the same cycle. It also drops any
    // result that is still waiting for downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            flags_p1  <= 4'b0000;
        end else if (accept_p0) begin
            vld_p1    <= 1'b1;
            result_p1 <= res_p0;
            if (i_set_flags) begin
                flags_p1 <= flags_p0;
            end
        end else if (i_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign o_valid  = vld_p1;
    assign o_result = result_p1;
    assign o_nzcv   = flags_p1;

endmodule

// File: tb/tb_alu_nzcv_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_nzcv_pipe
//
// Directed bench for alu_nzcv_pipe with N=8. A reference model in the bench
// tracks the expected handshake state, result and flags using plain integer
// arithmetic. One compare process checks the DUT against that model on every
// negative clock edge. Hand-computed literal values are checked at key points
// of the directed sequence.
// -----------------------------------------------------------------------------
module tb_alu_nzcv_pipe;

    localparam int W = 8;

    logic         clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [2:0]   i_alu_ctrl;
    logic         i_set_flags;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic [3:0]   o_nzcv;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    alu_nzcv_pipe #(.N(W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_alu_ctrl  (i_alu_ctrl),
        .i_set_flags (i_set_flags),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_nzcv      (o_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcode names.
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, ORR = 3'd3;
    localparam logic [2:0] ADC = 3'd4, SBC = 3'd5, EOR = 3'd6, MOV = 3'd7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic with signed range overflow.
    // Returns {nzcv, result}.
    function automatic logic [11:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic c_in);
        int ua, ub, sa, sb, r, sr, ci;
        logic [7:0] res;
        logic c, v, arith;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        ci = c_in ? 1 : 0;
        r = 0; sr = 0; c = 1'b0; arith = 1'b1;
        case (op)
            ADD: begin r = ua + ub;          c = (r > 255); sr = sa + sb; end
            SUB: begin r = ua - ub;          c = (r >= 0);  sr = sa - sb; end
            ADC: begin r = ua + ub + ci;     c = (r > 255); sr = sa + sb + ci; end
            SBC: begin r = ua - ub - (1-ci); c = (r >= 0);  sr = sa - sb - (1-ci); end
            AND: begin r = ua & ub; arith = 1'b0; end
            ORR: begin r = ua | ub; arith = 1'b0; end
            EOR: begin r = ua ^ ub; arith = 1'b0; end
            default: begin r = ub; arith = 1'b0; end
        endcase
        res = r[7:0];
        v = arith && ((sr > 127) || (sr < -128));
        return {res[7], (res == 8'h00), c, v, res};
    endfunction

    // Model state.
    logic       m_valid;
    logic [7:0] m_result;
    logic [3:0] m_nzcv;
    logic [11:0] m_calc;

    always @(posedge clk) begin
        if (i_rst) begin
            m_valid  <= 1'b0;
            m_result <= 8'h00;
            m_nzcv   <= 4'h0;
        end else if (i_valid && (!m_valid || i_ready)) begin
            m_calc = ref_op(i_alu_ctrl, i_a, i_b, m_nzcv[1]);
            m_valid  <= 1'b1;
            m_result <= m_calc[7:0];
            if (i_set_flags) m_nzcv <= m_calc[11:8];
        end else if (i_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
            chk("model_ready", {31'd0, o_ready}, {31'd0, (!m_valid || i_ready)});
            chk("model_nzcv",  {28'd0, o_nzcv},  {28'd0, m_nzcv});
            if (m_valid) chk("model_result", {24'd0, o_result}, {24'd0, m_result});
        end
    end

    task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic sf);
        i_valid = v; i_alu_ctrl = op; i_a = a; i_b = b; i_set_flags = sf;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic ev, input logic [7:0] er, input logic [3:0] en);
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, o_valid}, {31'd0, ev});
        chk({nm, "_result"}, {24'd0, o_result}, {24'd0, er});
        chk({nm, "_nzcv"}, {28'd0, o_nzcv}, {28'd0, en});
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sf;
        logic [7:0] er;
        logic [3:0] en;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{ORR, 8'hA0, 8'h05, 1'b1, 8'hA5, 4'b1000};
        tbl[1] = '{EOR, 8'hFF, 8'hFF, 1'b1, 8'h00, 4'b0100};
        tbl[2] = '{MOV, 8'h12, 8'h81, 1'b1, 8'h81, 4'b1000};
        tbl[3] = '{SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011};
        tbl[4] = '{ADD, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0111};
        tbl[5] = '{SBC, 8'h10, 8'h01, 1'b1, 8'h0F, 4'b0010};
        tbl[6] = '{ADC, 8'h7F, 8'h00, 1'b0, 8'h80, 4'b0010};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_alu_ctrl = ADD; i_set_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 1'b0, 8'h00, 4'b0000);
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        i_rst = 1'b0;
        chk_en = 1'b1;

        // ADD with signed overflow.
        step(1'b1, ADD, 8'h7F, 8'h01, 1'b1);
        lit("add_ovf", 1'b1, 8'h80, 4'b1001);

        // AND with flags held, then with flags set.
        step(1'b1, AND, 8'hF0, 8'h0F, 1'b0);
        lit("and_noflags", 1'b1, 8'h00, 4'b1001);
        step(1'b1, AND, 8'hF0, 8'h0F, 1'b1);
        lit("and_flags", 1'b1, 8'h00, 4'b0100);

        // Subtraction: equal operands, then a borrow.
        step(1'b1, SUB, 8'h05, 8'h05, 1'b1);
        lit("sub_eq", 1'b1, 8'h00, 4'b0110);
        step(1'b1, SUB, 8'h03, 8'h05, 1'b1);
        lit("sub_borrow", 1'b1, 8'hFE, 4'b1000);

        // Mixed opcodes, back to back.
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf);
            lit($sformatf("tbl%0d", i), 1'b1, tbl[i].er, tbl[i].en);
        end

        // Carry chain, back to back.
        step(1'b1, ADD, 8'hFF, 8'h01, 1'b1);
        lit("chain_add", 1'b1, 8'h00, 4'b0110);
        step(1'b1, ADC, 8'h00, 8'h00, 1'b1);
        lit("chain_adc", 1'b1, 8'h01, 4'b0000);
        step(1'b1, SBC, 8'h05, 8'h02, 1'b1);
        lit("chain_sbc", 1'b1, 8'h02, 4'b0010);

        // Backpressure.
        step(1'b1, ADD, 8'h10, 8'h20, 1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1; i_a = 8'h01; i_b = 8'h01;
        lit("bp_start", 1'b1, 8'h30, 4'b0010);
        chk("bp_start_ready", {31'd0, o_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, SUB, 8'h50 + 8'(k), 8'h11, 1'b1);
            lit($sformatf("bp_hold%0d", k), 1'b1, 8'h30, 4'b0010);
            chk($sformatf("bp_hold%0d_ready", k), {31'd0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        step(1'b1, ADD, 8'h40, 8'h02, 1'b0);
        lit("bp_release", 1'b1, 8'h42, 4'b0010);

        // Reset wins over an accept while a result is pending.
        step(1'b1, ADD, 8'h01, 8'h01, 1'b0);
        lit("pre_rst", 1'b1, 8'h02, 4'b0010);
        i_rst = 1'b1;
        step(1'b1, ADD, 8'h03, 8'h03, 1'b1);
        i_rst = 1'b0;
        lit("rst_drop", 1'b0, 8'h00, 4'b0000);

        // Streaming.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, ADD, 8'(k), 8'(k), 1'b1);
            lit($sformatf("stream%0d", k), 1'b1, 8'(2 * k), 4'b0000);
        end
        step(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        lit("drain", 1'b0, 8'h08, 4'b0000);
        step(1'b0, ADD, 8'h00, 8'h00, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
